ddr_fifo_rd_ctrl: RTL and testbench

//  Read-side controller for a single-clock (SYNC) ddr_fifo instance: issues pops, captures rdata into a
//  2-entry skid buffer and presents it as a valid/ready stream to the downstream datapath. Supports

---
 rtl/ddr_fifo_rd_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ddr_fifo_rd_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// ddr_fifo_rd_ctrl
//
// Read-side controller for a single-clock ddr_fifo. It issues pops to the FIFO,
// captures the combinational read data into a 2-entry skid buffer and presents
// it downstream as a valid/ready stream. Two modes are supported:
//   drain : pop whenever the FIFO is non-empty until i_stop
//   loop  : load the FIFO read pointer, then replay start..stop for
//           i_loop_cnt passes (0 = forever, ends only on i_stop)
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_stop     operation control pulses
//   i_loop_mode, i_start_ptr, i_stop_ptr, i_loop_cnt
//                       configuration, sampled on an accepted i_start
//   o_fifo_load_ptr     FIFO pointer-load strobe (LOAD state)
//   o_fifo_loop         FIFO loop-mode enable (held for the whole operation)
//   o_fifo_read         FIFO pop strobe
//   i_fifo_empty_n      FIFO non-empty flag
//   i_fifo_rdata        FIFO read data for the current read pointer
//   o_valid, o_data, i_ready
//                       output stream
//   o_busy, o_done      status (busy = not IDLE, done = 1-cycle pulse)
//   o_pass_cnt          completed loop passes
//   o_dbg_state         current FSM state encoding
//
// Stream handshake: a word transfers on every rising clock edge where
// o_valid && i_ready are both high. o_valid/o_data never depend on i_ready,
// and once o_valid is high it stays high with o_data stable until the
// transfer happens (or reset).
// ---------------------------------------------------------------------------
module ddr_fifo_rd_ctrl #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8,
    parameter int AWIDTH = $clog2(DEPTH),
    parameter int CWIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_mode,
    input  logic [AWIDTH-1:0] i_start_ptr,
    input  logic [AWIDTH-1:0] i_stop_ptr,
    input  logic [CWIDTH-1:0] i_loop_cnt,
    output logic              o_fifo_load_ptr,
    output logic              o_fifo_loop,
    output logic              o_fifo_read,
    input  logic              i_fifo_empty_n,
    input  logic [DWIDTH-1:0] i_fifo_rdata,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [CWIDTH-1:0] o_pass_cnt,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [AWIDTH-1:0] A_ONE = 1;
    localparam logic [CWIDTH-1:0] C_ONE = 1;

    state_t state_q, state_d;

    // Configuration captured on an accepted i_start
    logic              loop_q;
    logic [AWIDTH-1:0] start_ptr_q;
    logic [AWIDTH-1:0] stop_ptr_q;
    logic [CWIDTH-1:0] loop_cnt_q;

    // Loop progress
    logic [AWIDTH-1:0] entry_q;
    logic [CWIDTH-1:0] pass_q;
    logic [AWIDTH-1:0] len_m1;
    logic [CWIDTH-1:0] pass_inc;
    logic              last_entry;
    logic              last_pass;

    // Skid buffer: two slots, head/tail pointers and an occupancy count
    logic [DWIDTH-1:0] skid_mem [2];
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        cnt_q;

    logic              pop;
    logic              retire;

    // Loop length minus one; AWIDTH wrap makes stop<start span the end of
    // the FIFO and stop==start a single-entry loop.
    assign len_m1     = stop_ptr_q - start_ptr_q;
    assign pass_inc   = pass_q + C_ONE;
    assign last_entry = (entry_q == len_m1);
    assign last_pass  = (loop_cnt_q != '0) && (pass_inc == loop_cnt_q);

    // Pop decision uses registered state/count only, so i_ready never reaches
    // the FIFO read strobe. Loop mode ignores empty_n (pattern is preloaded).
    assign pop    = (state_q == S_RUN) && (cnt_q < 2'd2) &&
                    (loop_q || i_fifo_empty_n) && !i_stop;
    assign retire = o_valid && i_ready;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = i_loop_mode ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (i_stop) begin
                    state_d = S_FLUSH;
                end else if (pop && loop_q && last_entry && last_pass) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- state and configuration ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            loop_q      <= 1'b0;
            start_ptr_q <= '0;
            stop_ptr_q  <= '0;
            loop_cnt_q  <= '0;
            entry_q     <= '0;
            pass_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_start) begin
                loop_q      <= i_loop_mode;
                start_ptr_q <= i_start_ptr;
                stop_ptr_q  <= i_stop_ptr;
                loop_cnt_q  <= i_loop_cnt;
                entry_q     <= '0;
                pass_q      <= '0;
            end else if (state_q == S_DONE) begin
                // FIFO loop enable drops as the controller returns to IDLE
                loop_q <= 1'b0;
            end else if (pop && loop_q) begin
                if (last_entry) begin
                    entry_q <= '0;
                    pass_q  <= pass_inc;
                end else begin
                    entry_q <= entry_q + A_ONE;
                end
            end
        end
    end

    // ---------------- skid buffer ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            if (pop) begin
                skid_mem[wr_q] <= i_fifo_rdata;
                wr_q           <= ~wr_q;
            end
            if (retire) begin
                rd_q <= ~rd_q;
            end
            if (pop && !retire) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (!pop && retire) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_fifo_read     = pop;
    assign o_fifo_load_ptr = (state_q == S_LOAD);
    assign o_fifo_loop     = loop_q;
    assign o_valid         = (cnt_q != 2'd0);
    assign o_data          = skid_mem[rd_q];
    assign o_busy          = (state_q != S_IDLE);
    assign o_done          = (state_q == S_DONE);
    assign o_pass_cnt      = pass_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_ddr_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr_fifo_rd_ctrl
//
// Bench for ddr_fifo_rd_ctrl. A small behavioural FIFO model feeds the DUT.
// Directed tests push their hand-computed expected stream words into exp_q;
// a monitor pops and compares on every stream transfer and also counts pops,
// pointer loads and done pulses for the directed checks.
// ---------------------------------------------------------------------------
module tb_ddr_fifo_rd_ctrl;

    localparam int DW = 32;
    localparam int DP = 8;
    localparam int AW = 3;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    // ---------------- DUT signals ----------------
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic          i_loop_mode = 1'b0;
    logic [AW-1:0] i_start_ptr = '0;
    logic [AW-1:0] i_stop_ptr = '0;
    logic [CW-1:0] i_loop_cnt = '0;
    logic          o_fifo_load_ptr;
    logic          o_fifo_loop;
    logic          o_fifo_read;
    logic          i_fifo_empty_n;
    logic [DW-1:0] i_fifo_rdata;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic [CW-1:0] o_pass_cnt;
    logic [2:0]    o_dbg_state;

    ddr_fifo_rd_ctrl #(.DWIDTH(DW), .DEPTH(DP), .AWIDTH(AW), .CWIDTH(CW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_loop_mode    (i_loop_mode),
        .i_start_ptr    (i_start_ptr),
        .i_stop_ptr     (i_stop_ptr),
        .i_loop_cnt     (i_loop_cnt),
        .o_fifo_load_ptr(o_fifo_load_ptr),
        .o_fifo_loop    (o_fifo_loop),
        .o_fifo_read    (o_fifo_read),
        .i_fifo_empty_n (i_fifo_empty_n),
        .i_fifo_rdata   (i_fifo_rdata),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .i_ready        (i_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_pass_cnt     (o_pass_cnt),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fifo_mem [DP];
    logic [AW-1:0] m_rptr = '0;
    int            m_cnt = 0;
    logic          fill_go = 1'b0;
    int            fill_n = 0;
    logic [AW-1:0] cfg_start = '0;
    logic [AW-1:0] cfg_stop = '0;

    assign i_fifo_empty_n = (m_cnt != 0);
    assign i_fifo_rdata   = fifo_mem[m_rptr];

    initial begin
        forever begin
            @(posedge i_clk);
            if (fill_go) begin
                m_rptr <= '0;
                m_cnt  <= fill_n;
            end else if (o_fifo_load_ptr) begin
                m_rptr <= cfg_start;
            end else if (o_fifo_read) begin
                if (o_fifo_loop) begin
                    m_rptr <= (m_rptr == cfg_stop) ? cfg_start : m_rptr + 3'd1;
                end else begin
                    m_rptr <= m_rptr + 3'd1;
                    m_cnt  <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int load_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, between driver updates.
    initial begin
        logic [DW-1:0] exp_w;
        forever begin
            @(negedge i_clk);
            if (o_fifo_read) rd_cnt++;
            if (o_fifo_load_ptr) load_cnt++;
            if (o_done) done_cnt++;
            if (!i_rst && o_fifo_read && !o_fifo_loop) begin
                check("pop_nonempty", (m_cnt != 0) ? 32'd1 : 32'd0, 32'd1);
            end
            if (!i_rst && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_extra: got 0x%0h expected no word at %0t", o_data, $time);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("sb_data", o_data, exp_w);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic fifo_fill(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_mem[i] = base + DW'(i);
        fill_n  = n;
        fill_go = 1'b1;
        tick();
        fill_go = 1'b0;
    endtask

    task automatic start_op(input logic lm, input logic [AW-1:0] sp, input logic [AW-1:0] ep,
                            input logic [CW-1:0] lc);
        cfg_start   = sp;
        cfg_stop    = ep;
        i_loop_mode = lm;
        i_start_ptr = sp;
        i_stop_ptr  = ep;
        i_loop_cnt  = lc;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int k = 0; k < budget && o_busy; k++) tick();
        check(name, {31'd0, o_busy}, 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int rd0;
        int dn0;
        int ld0;

        // Reset state
        tick(); tick(); tick();
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_read", {31'd0, o_fifo_read}, 32'd0);
        check("rst_load", {31'd0, o_fifo_load_ptr}, 32'd0);
        check("rst_loop", {31'd0, o_fifo_loop}, 32'd0);
        check("rst_pass", {16'd0, o_pass_cnt}, 32'd0);
        check("rst_data", o_data, 32'd0);
        i_rst = 1'b0;
        tick();

        // Drain: 5 words, ready high -> 5 pops in 5 cycles, then none
        fifo_fill(32'hA0, 5);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'hA0 + DW'(i));
        i_ready = 1'b1;
        rd0 = rd_cnt; dn0 = done_cnt;
        start_op(1'b0, 3'd0, 3'd0, 16'd0);
        for (int i = 0; i < 5; i++) tick();
        check("drain_pops5", DW'(rd_cnt - rd0), 32'd5);
        tick(); tick(); tick();
        check("drain_no_pop_empty", {31'd0, o_fifo_read}, 32'd0);
        check("drain_pops_hold", DW'(rd_cnt - rd0), 32'd5);
        check("drain_sb_empty", DW'(exp_q.size()), 32'd0);
        pulse_stop();
        wait_idle("drain_idle", 20);
        check("drain_done", DW'(done_cnt - dn0), 32'd1);

        // Backpressure: 4 words, ready low -> only 2 pops
        fifo_fill(32'hB0, 4);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hB0 + DW'(i));
        i_ready = 1'b0;
        rd0 = rd_cnt; dn0 = done_cnt;
        start_op(1'b0, 3'd0, 3'd0, 16'd0);
        for (int i = 0; i < 6; i++) tick();
        check("bp_pops2", DW'(rd_cnt - rd0), 32'd2);
        check("bp_read_low", {31'd0, o_fifo_read}, 32'd0);
        check("bp_valid", {31'd0, o_valid}, 32'd1);
        check("bp_head", o_data, 32'hB0);
        // start while busy must be ignored
        i_loop_mode = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_loop_mode = 1'b0;
        check("bp_restart_ignored", {31'd0, o_fifo_loop}, 32'd0);
        check("bp_dbg_run", {29'd0, o_dbg_state}, 32'd2);
        i_ready = 1'b1;
        for (int k = 0; k < 30 && (m_cnt != 0 || exp_q.size() != 0); k++) tick();
        check("bp_drained", DW'(exp_q.size()), 32'd0);
        check("bp_pops4", DW'(rd_cnt - rd0), 32'd4);
        pulse_stop();
        wait_idle("bp_idle", 20);
        check("bp_done", DW'(done_cnt - dn0), 32'd1);

        // Loop patterns use fifo_mem[i] = 0xE0 + i, FIFO flagged empty
        fifo_fill(32'hE0, 0);
        for (int i = 0; i < DP; i++) fifo_mem[i] = 32'hE0 + DW'(i);

        // Loop start=2 stop=5 x3
        for (int p = 0; p < 3; p++)
            for (int i = 2; i <= 5; i++) exp_q.push_back(32'hE0 + DW'(i));
        rd0 = rd_cnt; dn0 = done_cnt; ld0 = load_cnt;
        start_op(1'b1, 3'd2, 3'd5, 16'd3);
        check("loop_load_hi", {31'd0, o_fifo_load_ptr}, 32'd1);
        check("loop_fifo_loop", {31'd0, o_fifo_loop}, 32'd1);
        tick();
        check("loop_load_lo", {31'd0, o_fifo_load_ptr}, 32'd0);
        wait_idle("loop_idle", 60);
        check("loop_load_cnt", DW'(load_cnt - ld0), 32'd1);
        check("loop_pops", DW'(rd_cnt - rd0), 32'd12);
        check("loop_pass", {16'd0, o_pass_cnt}, 32'd3);
        check("loop_done", DW'(done_cnt - dn0), 32'd1);
        check("loop_fifo_loop_off", {31'd0, o_fifo_loop}, 32'd0);
        check("loop_sb_empty", DW'(exp_q.size()), 32'd0);

        // Wrap start=6 stop=1 x1 -> e6 e7 e0 e1
        exp_q.push_back(32'hE6); exp_q.push_back(32'hE7);
        exp_q.push_back(32'hE0); exp_q.push_back(32'hE1);
        rd0 = rd_cnt;
        start_op(1'b1, 3'd6, 3'd1, 16'd1);
        wait_idle("wrap_idle", 40);
        check("wrap_pops", DW'(rd_cnt - rd0), 32'd4);
        check("wrap_pass", {16'd0, o_pass_cnt}, 32'd1);

        // Single-entry loop start=stop=3 x2
        exp_q.push_back(32'hE3); exp_q.push_back(32'hE3);
        rd0 = rd_cnt;
        start_op(1'b1, 3'd3, 3'd3, 16'd2);
        wait_idle("one_idle", 40);
        check("one_pops", DW'(rd_cnt - rd0), 32'd2);
        check("one_pass", {16'd0, o_pass_cnt}, 32'd2);
        check("one_sb_empty", DW'(exp_q.size()), 32'd0);

        // Infinite loop, full range; stop with 2 words buffered
        for (int i = 0; i < 11; i++) exp_q.push_back(32'hE0 + DW'(i % 8));
        rd0 = rd_cnt; dn0 = done_cnt;
        i_ready = 1'b1;
        start_op(1'b1, 3'd0, 3'd7, 16'd0);
        for (int k = 0; k < 40 && (rd_cnt - rd0) < 10; k++) tick();
        check("inf_reach10", ((rd_cnt - rd0) >= 10) ? 32'd1 : 32'd0, 32'd1);
        i_ready = 1'b0;
        tick();
        check("inf_pops11", DW'(rd_cnt - rd0), 32'd11);
        pulse_stop();
        for (int i = 0; i < 4; i++) tick();
        check("inf_no_pop_after_stop", DW'(rd_cnt - rd0), 32'd11);
        check("inf_flush_state", {29'd0, o_dbg_state}, 32'd3);
        check("inf_valid_held", {31'd0, o_valid}, 32'd1);
        check("inf_no_done_yet", DW'(done_cnt - dn0), 32'd0);
        check("inf_partial_pass", {16'd0, o_pass_cnt}, 32'd1);
        i_ready = 1'b1;
        wait_idle("inf_idle", 20);
        check("inf_done", DW'(done_cnt - dn0), 32'd1);
        check("inf_sb_empty", DW'(exp_q.size()), 32'd0);

        // Reset mid-RUN with skid full
        i_ready = 1'b0;
        rd0 = rd_cnt; dn0 = done_cnt;
        start_op(1'b1, 3'd0, 3'd7, 16'd0);
        for (int i = 0; i < 5; i++) tick();
        check("mrst_pre_pops", DW'(rd_cnt - rd0), 32'd2);
        check("mrst_pre_valid", {31'd0, o_valid}, 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mrst_valid", {31'd0, o_valid}, 32'd0);
        check("mrst_busy", {31'd0, o_busy}, 32'd0);
        check("mrst_loop", {31'd0, o_fifo_loop}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("mrst_no_done", DW'(done_cnt - dn0), 32'd0);
        check("mrst_idle_read", {31'd0, o_fifo_read}, 32'd0);

        check("final_sb_empty", DW'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
